// File: rtl/punc_control_fsm.sv
// punc_control_fsm
// Multicycle LC3 control unit for the PUnC processor. Sequences
// INIT -> FETCH -> DECODE -> EXEC (-> EXEC2) and decodes every datapath
// strobe and mux select from the current state, the instruction register
// and the branch-condition result supplied by the datapath.
module punc_control_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        nzp_match,
    output logic        pc_ld,
    output logic        pc_clr,
    output logic        pc_inc,
    output logic [1:0]  pc_sel,
    output logic        ir_ld,
    output logic        ir_clr,
    output logic        dmem_rd,
    output logic        dmem_wr,
    output logic [1:0]  dmem_r_addr_sel,
    output logic [1:0]  dmem_w_addr_sel,
    output logic [1:0]  rf_w_data_sel,
    output logic        rf_w_addr_sel,
    output logic        rf_w_wr,
    output logic        rf_rp_addr_sel,
    output logic        rf_rp_rd,
    output logic        rf_rq_rd,
    output logic        temp_ld,
    output logic        nzp_ld,
    output logic        nzp_clr,
    output logic [1:0]  alu_sel,
    output logic        alu_in_a_sel,
    output logic        halted
);

    // LC3 opcodes (ir[15:12])
    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RES  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // PC source selects
    localparam logic [1:0] PC_OFF9  = 2'd0;
    localparam logic [1:0] PC_OFF11 = 2'd1;
    localparam logic [1:0] PC_RQ    = 2'd2;

    // Memory read address selects
    localparam logic [1:0] RA_PC      = 2'd0;
    localparam logic [1:0] RA_PC_OFF9 = 2'd1;
    localparam logic [1:0] RA_RP      = 2'd2;
    localparam logic [1:0] RA_RQ_OFF6 = 2'd3;

    // Memory write address selects
    localparam logic [1:0] WA_PC_OFF9 = 2'd0;
    localparam logic [1:0] WA_TEMP    = 2'd1;
    localparam logic [1:0] WA_RQ_OFF6 = 2'd2;

    // Register file write data selects
    localparam logic [1:0] WD_ALU     = 2'd0;
    localparam logic [1:0] WD_PC_OFF9 = 2'd1;
    localparam logic [1:0] WD_MEM     = 2'd2;
    localparam logic [1:0] WD_PC      = 2'd3;

    // ALU operations
    localparam logic [1:0] ALU_ADD = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_NOT = 2'd3;

    typedef enum logic [2:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_EXEC2,
        S_HALT
    } state_t;

    state_t     state;
    logic [3:0] opcode;
    logic       unused_ir_fields;

    assign opcode           = ir[15:12];
    assign unused_ir_fields = ^{ir[10:6], ir[4:0]};

    // State sequencing; reset wins from any state, including mid-instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            case (state)
                S_INIT:   state <= S_FETCH;
                S_FETCH:  state <= S_DECODE;
                S_DECODE: state <= (opcode == OP_HALT) ? S_HALT : S_EXEC;
                S_EXEC:   state <= (opcode == OP_LDI || opcode == OP_STI) ? S_EXEC2 : S_FETCH;
                S_EXEC2:  state <= S_FETCH;
                S_HALT:   state <= S_HALT;
                default:  state <= S_INIT;
            endcase
        end
    end

    // Combinational decode of every strobe and select; anything not driven for a state stays 0
    always_comb begin
        pc_ld           = 1'b0;
        pc_clr          = 1'b0;
        pc_inc          = 1'b0;
        pc_sel          = 2'd0;
        ir_ld           = 1'b0;
        ir_clr          = 1'b0;
        dmem_rd         = 1'b0;
        dmem_wr         = 1'b0;
        dmem_r_addr_sel = 2'd0;
        dmem_w_addr_sel = 2'd0;
        rf_w_data_sel   = 2'd0;
        rf_w_addr_sel   = 1'b0;
        rf_w_wr         = 1'b0;
        rf_rp_addr_sel  = 1'b0;
        rf_rp_rd        = 1'b0;
        rf_rq_rd        = 1'b0;
        temp_ld         = 1'b0;
        nzp_ld          = 1'b0;
        nzp_clr         = 1'b0;
        alu_sel         = 2'd0;
        alu_in_a_sel    = 1'b0;
        halted          = 1'b0;

        case (state)
            S_INIT: begin
                pc_clr  = 1'b1;
                ir_clr  = 1'b1;
                nzp_clr = 1'b1;
            end

            S_FETCH: begin
                dmem_rd         = 1'b1;
                dmem_r_addr_sel = RA_PC;
                ir_ld           = 1'b1;
                pc_inc          = 1'b1;
            end

            S_DECODE: begin
                // Opcode inspection only; no datapath activity
            end

            S_EXEC: begin
                case (opcode)
                    OP_ADD, OP_AND: begin
                        alu_sel        = (opcode == OP_ADD) ? ALU_ADD : ALU_AND;
                        rf_rp_addr_sel = 1'b1;
                        rf_rq_rd       = 1'b1;
                        // ir[5] picks the imm5 operand instead of the second register
                        alu_in_a_sel   = ir[5];
                        rf_rp_rd       = ~ir[5];
                        rf_w_data_sel  = WD_ALU;
                        rf_w_addr_sel  = 1'b1;
                        rf_w_wr        = 1'b1;
                        nzp_ld         = 1'b1;
                    end

                    OP_NOT: begin
                        alu_sel       = ALU_NOT;
                        rf_rq_rd      = 1'b1;
                        rf_w_data_sel = WD_ALU;
                        rf_w_addr_sel = 1'b1;
                        rf_w_wr       = 1'b1;
                        nzp_ld        = 1'b1;
                    end

                    OP_BR: begin
                        pc_sel = PC_OFF9;
                        pc_ld  = nzp_match;
                    end

                    OP_JMP: begin
                        pc_sel   = PC_RQ;
                        rf_rq_rd = 1'b1;
                        pc_ld    = 1'b1;
                    end

                    OP_JSR: begin
                        // R7 takes the already-incremented PC on the same edge the PC
                        // jumps, so JSRR R7 still reads the old R7 as its target
                        rf_w_addr_sel = 1'b0;
                        rf_w_data_sel = WD_PC;
                        rf_w_wr       = 1'b1;
                        pc_ld         = 1'b1;
                        pc_sel        = ir[11] ? PC_OFF11 : PC_RQ;
                    end

                    OP_LD, OP_LDR: begin
                        dmem_rd         = 1'b1;
                        dmem_r_addr_sel = (opcode == OP_LD) ? RA_PC_OFF9 : RA_RQ_OFF6;
                        rf_w_data_sel   = WD_MEM;
                        rf_w_addr_sel   = 1'b1;
                        rf_w_wr         = 1'b1;
                        nzp_ld          = 1'b1;
                    end

                    OP_LEA: begin
                        rf_w_data_sel = WD_PC_OFF9;
                        rf_w_addr_sel = 1'b1;
                        rf_w_wr       = 1'b1;
                        nzp_ld        = 1'b1;
                    end

                    OP_ST, OP_STR: begin
                        rf_rp_addr_sel  = 1'b0;
                        rf_rp_rd        = 1'b1;
                        dmem_w_addr_sel = (opcode == OP_ST) ? WA_PC_OFF9 : WA_RQ_OFF6;
                        dmem_wr         = 1'b1;
                    end

                    OP_LDI: begin
                        // Pointer lands in DR first; NZP waits for the final value in EXEC2
                        dmem_rd         = 1'b1;
                        dmem_r_addr_sel = RA_PC_OFF9;
                        rf_w_data_sel   = WD_MEM;
                        rf_w_addr_sel   = 1'b1;
                        rf_w_wr         = 1'b1;
                    end

                    OP_STI: begin
                        // Pointer is parked in temp for the EXEC2 write address
                        dmem_rd         = 1'b1;
                        dmem_r_addr_sel = RA_PC_OFF9;
                        temp_ld         = 1'b1;
                    end

                    OP_RTI, OP_RES, OP_HALT: begin
                        // No datapath activity
                    end

                    default: begin
                    end
                endcase
            end

            S_EXEC2: begin
                if (opcode == OP_LDI) begin
                    // DR now holds the pointer; read through it back into DR
                    rf_rp_addr_sel  = 1'b0;
                    dmem_r_addr_sel = RA_RP;
                    rf_w_data_sel   = WD_MEM;
                    rf_w_addr_sel   = 1'b1;
                    rf_w_wr         = 1'b1;
                    nzp_ld          = 1'b1;
                end else if (opcode == OP_STI) begin
                    dmem_w_addr_sel = WA_TEMP;
                    rf_rp_addr_sel  = 1'b0;
                    rf_rp_rd        = 1'b1;
                    dmem_wr         = 1'b1;
                end
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_punc_control_fsm.sv
// tb_punc_control_fsm
// Scoreboard bench for the PUnC control FSM: each scenario queues the
// control word expected in every cycle, then walks the clock and compares.
module tb_punc_control_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ir = 16'h0000;
    logic        nzp_match = 1'b0;
    logic        pc_ld, pc_clr, pc_inc, ir_ld, ir_clr, dmem_rd, dmem_wr;
    logic [1:0]  pc_sel, dmem_r_addr_sel, dmem_w_addr_sel, rf_w_data_sel, alu_sel;
    logic        rf_w_addr_sel, rf_w_wr, rf_rp_addr_sel, rf_rp_rd, rf_rq_rd;
    logic        temp_ld, nzp_ld, nzp_clr, alu_in_a_sel, halted;

    int checks = 0;
    int errors = 0;
    bit watch_wr = 1'b0;
    bit wr_seen  = 1'b0;

    typedef struct packed {
        logic       pc_ld;
        logic       pc_clr;
        logic       pc_inc;
        logic [1:0] pc_sel;
        logic       ir_ld;
        logic       ir_clr;
        logic       dmem_rd;
        logic       dmem_wr;
        logic [1:0] dmem_r_addr_sel;
        logic [1:0] dmem_w_addr_sel;
        logic [1:0] rf_w_data_sel;
        logic       rf_w_addr_sel;
        logic       rf_w_wr;
        logic       rf_rp_addr_sel;
        logic       rf_rp_rd;
        logic       rf_rq_rd;
        logic       temp_ld;
        logic       nzp_ld;
        logic       nzp_clr;
        logic [1:0] alu_sel;
        logic       alu_in_a_sel;
        logic       halted;
    } ctrl_t;

    typedef struct {
        ctrl_t exp;
        bit    rst_after;
        string tag;
    } sb_t;

    sb_t sbq[$];

    punc_control_fsm dut (
        .clk(clk), .rst(rst), .ir(ir), .nzp_match(nzp_match),
        .pc_ld(pc_ld), .pc_clr(pc_clr), .pc_inc(pc_inc), .pc_sel(pc_sel),
        .ir_ld(ir_ld), .ir_clr(ir_clr), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
        .dmem_r_addr_sel(dmem_r_addr_sel), .dmem_w_addr_sel(dmem_w_addr_sel),
        .rf_w_data_sel(rf_w_data_sel), .rf_w_addr_sel(rf_w_addr_sel), .rf_w_wr(rf_w_wr),
        .rf_rp_addr_sel(rf_rp_addr_sel), .rf_rp_rd(rf_rp_rd), .rf_rq_rd(rf_rq_rd),
        .temp_ld(temp_ld), .nzp_ld(nzp_ld), .nzp_clr(nzp_clr),
        .alu_sel(alu_sel), .alu_in_a_sel(alu_in_a_sel), .halted(halted)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (watch_wr && dmem_wr === 1'b1) wr_seen = 1'b1;

    function automatic ctrl_t obs();
        ctrl_t c;
        c = '{pc_ld, pc_clr, pc_inc, pc_sel, ir_ld, ir_clr, dmem_rd, dmem_wr,
              dmem_r_addr_sel, dmem_w_addr_sel, rf_w_data_sel, rf_w_addr_sel, rf_w_wr,
              rf_rp_addr_sel, rf_rp_rd, rf_rq_rd, temp_ld, nzp_ld, nzp_clr,
              alu_sel, alu_in_a_sel, halted};
        return c;
    endfunction

    function automatic ctrl_t k_init();
        ctrl_t c = '0;
        c.pc_clr = 1'b1; c.ir_clr = 1'b1; c.nzp_clr = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t k_fetch();
        ctrl_t c = '0;
        c.dmem_rd = 1'b1; c.dmem_r_addr_sel = 2'd0; c.ir_ld = 1'b1; c.pc_inc = 1'b1;
        return c;
    endfunction

    // Register write to DR with condition-code update
    function automatic ctrl_t k_wr_dr(input logic [1:0] data_sel);
        ctrl_t c = '0;
        c.rf_w_data_sel = data_sel; c.rf_w_addr_sel = 1'b1; c.rf_w_wr = 1'b1; c.nzp_ld = 1'b1;
        return c;
    endfunction

    task automatic push(input ctrl_t e, input bit r, input string tag);
        sb_t s;
        s.exp = e; s.rst_after = r; s.tag = tag;
        sbq.push_back(s);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        ctrl_t e;
        ir = 16'h1262; nzp_match = 1'b0;
        pulse_reset();
        push(k_init(), 0, "reset_init");
        push(k_fetch(), 0, "reset_fetch");
        push('0, 0, "reset_decode");
        e = k_wr_dr(2'd0);
        e.alu_sel = 2'd1; e.alu_in_a_sel = 1'b1; e.rf_rp_addr_sel = 1'b1; e.rf_rq_rd = 1'b1;
        push(e, 0, "add_imm_exec");
        push(k_fetch(), 0, "add_imm_next_fetch");
        while (sbq.size() > 0) begin
            sb_t s = sbq.pop_front();
            #1;
            checks++;
            if (obs() !== s.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", s.tag, obs(), s.exp);
            end
            rst = s.rst_after;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu();
        logic [15:0] ins [4] = '{16'h1042, 16'h5262, 16'h5042, 16'h907F};
        ctrl_t ex [4];
        ex[0] = k_wr_dr(2'd0); ex[0].alu_sel = 2'd1; ex[0].rf_rp_addr_sel = 1'b1;
        ex[0].rf_rq_rd = 1'b1; ex[0].rf_rp_rd = 1'b1;
        ex[1] = k_wr_dr(2'd0); ex[1].alu_sel = 2'd2; ex[1].rf_rp_addr_sel = 1'b1;
        ex[1].rf_rq_rd = 1'b1; ex[1].alu_in_a_sel = 1'b1;
        ex[2] = k_wr_dr(2'd0); ex[2].alu_sel = 2'd2; ex[2].rf_rp_addr_sel = 1'b1;
        ex[2].rf_rq_rd = 1'b1; ex[2].rf_rp_rd = 1'b1;
        ex[3] = k_wr_dr(2'd0); ex[3].alu_sel = 2'd3; ex[3].rf_rq_rd = 1'b1;
        pulse_reset();
        push(k_init(), 0, "alu_init");
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) begin
                ir = ins[i-1];
                push(k_fetch(), 0, $sformatf("alu%0d_fetch", i-1));
                push('0, 0, $sformatf("alu%0d_decode", i-1));
                push(ex[i-1], 0, $sformatf("alu%0d_exec_%h", i-1, ins[i-1]));
            end
            while (sbq.size() > 0) begin
                sb_t s = sbq.pop_front();
                #1;
                checks++;
                if (obs() !== s.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", s.tag, obs(), s.exp);
                end
                rst = s.rst_after;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_branch();
        ctrl_t e;
        pulse_reset();
        ir = 16'h0405;
        push(k_init(), 0, "br_init");
        for (int k = 0; k < 2; k++) begin
            nzp_match = (k == 1);
            e = '0;
            e.pc_sel = 2'd0; e.pc_ld = (k == 1);
            push(k_fetch(), 0, "br_fetch");
            push('0, 0, "br_decode");
            push(e, 0, (k == 1) ? "brz_taken" : "brz_not_taken");
            while (sbq.size() > 0) begin
                sb_t s = sbq.pop_front();
                #1;
                checks++;
                if (obs() !== s.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", s.tag, obs(), s.exp);
                end
                rst = s.rst_after;
                @(posedge clk); #1;
            end
        end
        nzp_match = 1'b0;
    endtask

    task automatic test_jumps();
        logic [15:0] ins [3] = '{16'h4805, 16'h4080, 16'hC1C0};
        ctrl_t ex [3];
        ex[0] = '0; ex[0].rf_w_data_sel = 2'd3; ex[0].rf_w_wr = 1'b1;
        ex[0].pc_ld = 1'b1; ex[0].pc_sel = 2'd1;
        ex[1] = ex[0]; ex[1].pc_sel = 2'd2;
        ex[2] = '0; ex[2].pc_sel = 2'd2; ex[2].rf_rq_rd = 1'b1; ex[2].pc_ld = 1'b1;
        pulse_reset();
        push(k_init(), 0, "jmp_init");
        for (int i = 0; i <= 3; i++) begin
            if (i > 0) begin
                ir = ins[i-1];
                push(k_fetch(), 0, "jmp_fetch");
                push('0, 0, "jmp_decode");
                push(ex[i-1], 0, $sformatf("jump_exec_%h", ins[i-1]));
            end
            while (sbq.size() > 0) begin
                sb_t s = sbq.pop_front();
                #1;
                checks++;
                if (obs() !== s.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", s.tag, obs(), s.exp);
                end
                rst = s.rst_after;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_mem();
        logic [15:0] ins [7] = '{16'h2203, 16'h6283, 16'hE205, 16'h3203, 16'h7283, 16'h8000, 16'hD000};
        ctrl_t ex [7];
        ex[0] = k_wr_dr(2'd2); ex[0].dmem_rd = 1'b1; ex[0].dmem_r_addr_sel = 2'd1;
        ex[1] = k_wr_dr(2'd2); ex[1].dmem_rd = 1'b1; ex[1].dmem_r_addr_sel = 2'd3;
        ex[2] = k_wr_dr(2'd1);
        ex[3] = '0; ex[3].rf_rp_rd = 1'b1; ex[3].dmem_w_addr_sel = 2'd0; ex[3].dmem_wr = 1'b1;
        ex[4] = ex[3]; ex[4].dmem_w_addr_sel = 2'd2;
        ex[5] = '0;
        ex[6] = '0;
        pulse_reset();
        push(k_init(), 0, "mem_init");
        for (int i = 0; i <= 7; i++) begin
            if (i > 0) begin
                ir = ins[i-1];
                push(k_fetch(), 0, "mem_fetch");
                push('0, 0, "mem_decode");
                push(ex[i-1], 0, $sformatf("mem_exec_%h", ins[i-1]));
            end
            while (sbq.size() > 0) begin
                sb_t s = sbq.pop_front();
                #1;
                checks++;
                if (obs() !== s.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", s.tag, obs(), s.exp);
                end
                rst = s.rst_after;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_ldi_sti();
        ctrl_t e;
        pulse_reset();
        ir = 16'hA203;
        push(k_init(), 0, "ldi_init");
        push(k_fetch(), 0, "ldi_fetch");
        push('0, 0, "ldi_decode");
        e = k_wr_dr(2'd2); e.dmem_rd = 1'b1; e.dmem_r_addr_sel = 2'd1; e.nzp_ld = 1'b0;
        push(e, 0, "ldi_exec");
        e = k_wr_dr(2'd2); e.dmem_r_addr_sel = 2'd2; e.rf_rp_addr_sel = 1'b0;
        push(e, 0, "ldi_exec2");
        push(k_fetch(), 0, "ldi_next_fetch");
        while (sbq.size() > 0) begin
            sb_t s = sbq.pop_front();
            #1;
            checks++;
            if (obs() !== s.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", s.tag, obs(), s.exp);
            end
            rst = s.rst_after;
            @(posedge clk); #1;
        end
        ir = 16'hB203;
        push('0, 0, "sti_decode");
        e = '0; e.dmem_rd = 1'b1; e.dmem_r_addr_sel = 2'd1; e.temp_ld = 1'b1;
        push(e, 0, "sti_exec");
        e = '0; e.dmem_w_addr_sel = 2'd1; e.rf_rp_rd = 1'b1; e.dmem_wr = 1'b1;
        push(e, 0, "sti_exec2");
        push(k_fetch(), 0, "sti_next_fetch");
        while (sbq.size() > 0) begin
            sb_t s = sbq.pop_front();
            #1;
            checks++;
            if (obs() !== s.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", s.tag, obs(), s.exp);
            end
            rst = s.rst_after;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt();
        ctrl_t h = '0;
        h.halted = 1'b1;
        pulse_reset();
        ir = 16'hF025;
        push(k_init(), 0, "halt_init");
        push(k_fetch(), 0, "halt_fetch");
        push('0, 0, "halt_decode");
        for (int i = 0; i < 10; i++) push(h, 0, $sformatf("halt_cycle%0d", i));
        while (sbq.size() > 0) begin
            sb_t s = sbq.pop_front();
            #1;
            checks++;
            if (obs() !== s.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", s.tag, obs(), s.exp);
            end
            rst = s.rst_after;
            @(posedge clk); #1;
        end
        ir = 16'h1262;
        push(h, 0, "halt_sticky_new_ir");
        push(h, 1, "halt_before_rst");
        push(k_init(), 0, "halt_rst_init");
        push(k_fetch(), 0, "halt_rst_fetch");
        while (sbq.size() > 0) begin
            sb_t s = sbq.pop_front();
            #1;
            checks++;
            if (obs() !== s.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", s.tag, obs(), s.exp);
            end
            rst = s.rst_after;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_sti();
        ctrl_t e;
        pulse_reset();
        ir = 16'hB203;
        wr_seen = 1'b0;
        watch_wr = 1'b1;
        push(k_init(), 0, "midrst_init");
        push(k_fetch(), 0, "midrst_fetch");
        push('0, 0, "midrst_decode");
        e = '0; e.dmem_rd = 1'b1; e.dmem_r_addr_sel = 2'd1; e.temp_ld = 1'b1;
        push(e, 1, "midrst_sti_exec");
        push(k_init(), 0, "midrst_reinit");
        push(k_fetch(), 0, "midrst_refetch");
        while (sbq.size() > 0) begin
            sb_t s = sbq.pop_front();
            #1;
            checks++;
            if (obs() !== s.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", s.tag, obs(), s.exp);
            end
            rst = s.rst_after;
            @(posedge clk); #1;
        end
        watch_wr = 1'b0;
        checks++;
        if (wr_seen !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_write: dmem_wr seen %0b expected 0", wr_seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ins [4] = '{16'h1262, 16'hA203, 16'h7283, 16'h0405};
        pulse_reset();
        nzp_match = 1'b1;
        push(k_init(), 0, "b2b_init");
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) begin
                ctrl_t e;
                ir = ins[i-1];
                push(k_fetch(), 0, "b2b_fetch");
                push('0, 0, "b2b_decode");
                case (i)
                    1: begin
                        e = k_wr_dr(2'd0); e.alu_sel = 2'd1; e.alu_in_a_sel = 1'b1;
                        e.rf_rp_addr_sel = 1'b1; e.rf_rq_rd = 1'b1;
                        push(e, 0, "b2b_add");
                    end
                    2: begin
                        e = k_wr_dr(2'd2); e.dmem_rd = 1'b1; e.dmem_r_addr_sel = 2'd1; e.nzp_ld = 1'b0;
                        push(e, 0, "b2b_ldi_exec");
                        e = k_wr_dr(2'd2); e.dmem_r_addr_sel = 2'd2;
                        push(e, 0, "b2b_ldi_exec2");
                    end
                    3: begin
                        e = '0; e.rf_rp_rd = 1'b1; e.dmem_w_addr_sel = 2'd2; e.dmem_wr = 1'b1;
                        push(e, 0, "b2b_str");
                    end
                    default: begin
                        e = '0; e.pc_ld = 1'b1;
                        push(e, 0, "b2b_br_taken");
                    end
                endcase
            end
            while (sbq.size() > 0) begin
                sb_t s = sbq.pop_front();
                #1;
                checks++;
                if (obs() !== s.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", s.tag, obs(), s.exp);
                end
                rst = s.rst_after;
                @(posedge clk); #1;
            end
        end
        nzp_match = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_jumps();
        test_mem();
        test_ldi_sti();
        test_halt();
        test_reset_mid_sti();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
